obi_2_axi_pipe: RTL

Pipelined OBI-to-AXI4 manager bridge for the dual-helix core-side interconnect. It accepts up to MAX_OUTSTANDING OBI transactions in flight and issues each one as a single-beat AXI read (AR→R) or write (AW+W→B). It returns OBI responses strictly in request order and maps AXI SLVERR/DECERR onto OBI `err_o`. It sits between a core's OBI data/instruction port and the AXI crossbar.

---
 rtl/obi_2_axi_pipe_if.sv | 92 +++++++++
 rtl/obi_2_axi_pipe.sv | 106 ++++++++++
 2 files changed

// File: rtl/obi_2_axi_pipe_if.sv
// obi_2_axi_pipe_if: OBI port plus single-beat AXI4 manager channels of the bridge
interface obi_2_axi_pipe_if #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter int IDW = 4
) ();
  localparam int STRBW = DATAW / 8;
  logic             req;
  logic             gnt;
  logic [ADDRW-1:0] addr;
  logic             we;
  logic [STRBW-1:0] be;
  logic [DATAW-1:0] wdata;
  logic             rvalid;
  logic [DATAW-1:0] rdata;
  logic             err;
  logic             aw_valid;
  logic             aw_ready;
  logic [IDW-1:0]   aw_id;
  logic [ADDRW-1:0] aw_addr;
  logic [7:0]       aw_len;
  logic [2:0]       aw_size;
  logic [1:0]       aw_burst;
  logic             aw_lock;
  logic [3:0]       aw_cache;
  logic [2:0]       aw_prot;
  logic [3:0]       aw_qos;
  logic [3:0]       aw_region;
  logic [5:0]       aw_atop;
  logic             aw_user;
  logic             w_valid;
  logic             w_ready;
  logic [DATAW-1:0] w_data;
  logic [STRBW-1:0] w_strb;
  logic             w_last;
  logic             w_user;
  logic             b_valid;
  logic             b_ready;
  logic [IDW-1:0]   b_id;
  logic [1:0]       b_resp;
  logic             ar_valid;
  logic             ar_ready;
  logic [IDW-1:0]   ar_id;
  logic [ADDRW-1:0] ar_addr;
  logic [7:0]       ar_len;
  logic [2:0]       ar_size;
  logic [1:0]       ar_burst;
  logic             ar_lock;
  logic [3:0]       ar_cache;
  logic [2:0]       ar_prot;
  logic [3:0]       ar_qos;
  logic [3:0]       ar_region;
  logic             ar_user;
  logic             r_valid;
  logic             r_ready;
  logic [IDW-1:0]   r_id;
  logic [DATAW-1:0] r_data;
  logic [1:0]       r_resp;
  logic             r_last;
  modport master (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err,
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_atop, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );
  modport slave (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err,
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_atop, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/obi_2_axi_pipe.sv
// obi_2_axi_pipe: pipelined OBI-to-AXI4 bridge, single-beat transfers, in-order responses
module obi_2_axi_pipe #(
  parameter int OBI_ADDRW = 32,
  parameter int OBI_DATAW = 32,
  parameter int OBI_STRBW = OBI_DATAW / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AXI_ID = 0,
  parameter int AXI_IDW = 4
) (
  input logic clk_i,
  input logic rst_i,
  obi_2_axi_pipe_if.master bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  logic                       ar_valid, aw_valid, w_valid;
  logic [OBI_ADDRW-1:0]       addr_q;
  logic [OBI_STRBW-1:0]       be_q;
  logic [OBI_DATAW-1:0]       wdata_q;
  logic [MAX_OUTSTANDING-1:0] order;
  logic [PW-1:0]              wptr, rptr;
  logic [CW-1:0]              cnt;
  logic                       rvalid_q, err_q;
  logic [OBI_DATAW-1:0]       rdata_q;
  logic slot_free, gnt, busy, head, r_hs, b_hs, pop;
  logic unused_ok;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction
  assign slot_free = (~ar_valid | bus.ar_ready) & (~aw_valid | bus.aw_ready) & (~w_valid | bus.w_ready);
  assign gnt = bus.req & slot_free & (cnt < CW'(MAX_OUTSTANDING)) & ~rst_i;
  // the order FIFO head decides which response channel may be accepted
  assign busy = cnt != '0;
  assign head = order[rptr];
  assign bus.r_ready = busy & ~head;
  assign bus.b_ready = busy & head;
  assign r_hs = bus.r_valid & bus.r_ready;
  assign b_hs = bus.b_valid & bus.b_ready;
  assign pop = r_hs | b_hs;
  assign bus.gnt = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata = rdata_q;
  assign bus.err = err_q;
  assign bus.aw_valid = aw_valid;
  assign bus.aw_id = AXI_IDW'(AXI_ID);
  assign bus.aw_addr = addr_q;
  assign bus.aw_len = '0;
  assign bus.aw_size = 3'($clog2(OBI_STRBW));
  assign bus.aw_burst = 2'b01;
  assign bus.aw_lock = 1'b0;
  assign bus.aw_cache = '0;
  assign bus.aw_prot = '0;
  assign bus.aw_qos = '0;
  assign bus.aw_region = '0;
  assign bus.aw_atop = '0;
  assign bus.aw_user = 1'b0;
  assign bus.w_valid = w_valid;
  assign bus.w_data = wdata_q;
  assign bus.w_strb = be_q;
  assign bus.w_last = 1'b1;
  assign bus.w_user = 1'b0;
  assign bus.ar_valid = ar_valid;
  assign bus.ar_id = AXI_IDW'(AXI_ID);
  assign bus.ar_addr = addr_q;
  assign bus.ar_len = '0;
  assign bus.ar_size = 3'($clog2(OBI_STRBW));
  assign bus.ar_burst = 2'b01;
  assign bus.ar_lock = 1'b0;
  assign bus.ar_cache = '0;
  assign bus.ar_prot = '0;
  assign bus.ar_qos = '0;
  assign bus.ar_region = '0;
  assign bus.ar_user = 1'b0;
  assign unused_ok = ^{bus.r_last, bus.r_id, bus.b_id, bus.r_resp[0], bus.b_resp[0]};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_valid <= 1'b0;
      aw_valid <= 1'b0;
      w_valid <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      ar_valid <= (gnt & ~bus.we) | (ar_valid & ~bus.ar_ready);
      aw_valid <= (gnt & bus.we) | (aw_valid & ~bus.aw_ready);
      w_valid <= (gnt & bus.we) | (w_valid & ~bus.w_ready);
      if (gnt) begin
        addr_q <= bus.addr;
        be_q <= bus.be;
        wdata_q <= bus.wdata;
        order[wptr] <= bus.we;
        wptr <= nxt(wptr);
      end
      if (pop) begin
        rptr <= nxt(rptr);
        rdata_q <= r_hs ? bus.r_data : '0;
        err_q <= r_hs ? bus.r_resp[1] : bus.b_resp[1];
      end
      cnt <= cnt + CW'(gnt) - CW'(pop);
      rvalid_q <= pop;
    end
  end
endmodule
